// File: rtl/imm_field_decoder_if.sv
// Handshake and data bundle for the RV32I decode-stage immediate field decoder.
// The fetch side and the downstream consumer both sit on the master modport.
interface imm_field_decoder_if #(
    parameter int unsigned PC_WIDTH  = 32,
    parameter int unsigned CNT_WIDTH = 16
);

    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          in_inst;
    logic [PC_WIDTH-1:0]  in_pc;
    logic                 flush;

    logic                 out_valid;
    logic                 out_ready;
    logic [31:0]          out_inst;
    logic [PC_WIDTH-1:0]  out_pc;
    logic [11:0]          out_imm12;
    logic [2:0]           out_imm_fmt;
    logic                 out_illegal;
    logic [CNT_WIDTH-1:0] stall_cnt;

    modport master (
        output in_valid,
        output in_inst,
        output in_pc,
        output flush,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_inst,
        input  out_pc,
        input  out_imm12,
        input  out_imm_fmt,
        input  out_illegal,
        input  stall_cnt
    );

    modport slave (
        input  in_valid,
        input  in_inst,
        input  in_pc,
        input  flush,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_inst,
        output out_pc,
        output out_imm12,
        output out_imm_fmt,
        output out_illegal,
        output stall_cnt
    );

endinterface

// File: rtl/imm_field_decoder.sv
// Decode-stage register slice: holds one instruction/PC, classifies its format,
// extracts the 12-bit immediate and counts back-pressure stall cycles.
module imm_field_decoder #(
    parameter int unsigned PC_WIDTH  = 32,
    parameter int unsigned CNT_WIDTH = 16
) (
    input logic               clk,
    input logic               rst,
    imm_field_decoder_if.slave bus
);

    typedef enum logic [2:0] {
        FmtNone = 3'd0,
        FmtI    = 3'd1,
        FmtS    = 3'd2,
        FmtB    = 3'd3,
        FmtU    = 3'd4,
        FmtJ    = 3'd5
    } imm_fmt_e;

    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpSystem = 7'b1110011;
    localparam logic [6:0] OpFence  = 7'b0001111;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpReg    = 7'b0110011;

    localparam logic [31:0]          NopInst  = 32'h0000_0013;
    localparam logic [CNT_WIDTH-1:0] CntMax   = {CNT_WIDTH{1'b1}};

    logic                 out_valid_q,   out_valid_d;
    logic [31:0]          out_inst_q,    out_inst_d;
    logic [PC_WIDTH-1:0]  out_pc_q,      out_pc_d;
    logic [11:0]          out_imm12_q,   out_imm12_d;
    imm_fmt_e             out_imm_fmt_q, out_imm_fmt_d;
    logic                 out_illegal_q, out_illegal_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q,   stall_cnt_d;

    logic [11:0] dec_imm12;
    imm_fmt_e    dec_fmt;
    logic        dec_illegal;
    logic        in_ready;
    logic        load;

    // Decode straight from the incoming word so the result is captured with it.
    always_comb begin
        dec_imm12   = 12'h000;
        dec_fmt     = FmtNone;
        dec_illegal = 1'b1;
        if (bus.in_inst[1:0] == 2'b11) begin
            case (bus.in_inst[6:0])
                OpImm, OpLoad, OpJalr, OpSystem, OpFence: begin
                    dec_imm12   = bus.in_inst[31:20];
                    dec_fmt     = FmtI;
                    dec_illegal = 1'b0;
                end
                OpStore: begin
                    dec_imm12   = {bus.in_inst[31:25], bus.in_inst[11:7]};
                    dec_fmt     = FmtS;
                    dec_illegal = 1'b0;
                end
                OpBranch: begin
                    // Half-offset; the sign extender shifts left by one.
                    dec_imm12   = {bus.in_inst[31], bus.in_inst[7],
                                   bus.in_inst[30:25], bus.in_inst[11:8]};
                    dec_fmt     = FmtB;
                    dec_illegal = 1'b0;
                end
                OpLui, OpAuipc: begin
                    dec_fmt     = FmtU;
                    dec_illegal = 1'b0;
                end
                OpJal: begin
                    dec_fmt     = FmtJ;
                    dec_illegal = 1'b0;
                end
                OpReg: begin
                    dec_illegal = 1'b0;
                end
                default: begin
                    dec_illegal = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        in_ready = !bus.flush && (!out_valid_q || bus.out_ready);
        load     = bus.in_valid && in_ready;
    end

    always_comb begin
        out_valid_d   = out_valid_q;
        out_inst_d    = out_inst_q;
        out_pc_d      = out_pc_q;
        out_imm12_d   = out_imm12_q;
        out_imm_fmt_d = out_imm_fmt_q;
        out_illegal_d = out_illegal_q;
        stall_cnt_d   = stall_cnt_q;

        if (out_valid_q && !bus.out_ready && (stall_cnt_q != CntMax)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end

        if (bus.flush) begin
            out_valid_d = 1'b0;
        end else if (load) begin
            out_valid_d   = 1'b1;
            out_inst_d    = bus.in_inst;
            out_pc_d      = bus.in_pc;
            out_imm12_d   = dec_imm12;
            out_imm_fmt_d = dec_fmt;
            out_illegal_d = dec_illegal;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q   <= 1'b0;
            out_inst_q    <= NopInst;
            out_pc_q      <= '0;
            out_imm12_q   <= 12'h000;
            out_imm_fmt_q <= FmtNone;
            out_illegal_q <= 1'b0;
            stall_cnt_q   <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_inst_q    <= out_inst_d;
            out_pc_q      <= out_pc_d;
            out_imm12_q   <= out_imm12_d;
            out_imm_fmt_q <= out_imm_fmt_d;
            out_illegal_q <= out_illegal_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_inst    = out_inst_q;
    assign bus.out_pc      = out_pc_q;
    assign bus.out_imm12   = out_imm12_q;
    assign bus.out_imm_fmt = out_imm_fmt_q;
    assign bus.out_illegal = out_illegal_q;
    assign bus.stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_imm_field_decoder.sv
// Randomised plus directed bench for imm_field_decoder against a behavioural model.
module tb_imm_field_decoder;

    localparam int unsigned PW = 32;
    localparam int unsigned CW = 4;  // narrow counter so saturation is reachable
    localparam int          CNT_MAX = (1 << CW) - 1;

    logic clk;
    logic rst;

    imm_field_decoder_if #(.PC_WIDTH(PW), .CNT_WIDTH(CW)) ifc ();

    imm_field_decoder #(.PC_WIDTH(PW), .CNT_WIDTH(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference state
    bit          m_valid;
    logic [31:0] m_inst;
    logic [31:0] m_pc;
    logic [11:0] m_imm;
    logic [2:0]  m_fmt;
    bit          m_ill;
    int          m_cnt;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void ref_decode(input logic [31:0] w, output logic [11:0] imm,
                                       output logic [2:0] fmt, output bit ill);
        logic [6:0] op;
        op  = w[6:0];
        imm = 12'h0;
        fmt = 3'd0;
        ill = 1'b0;
        if (w[1:0] != 2'b11) ill = 1'b1;
        else if (op inside {7'h13, 7'h03, 7'h67, 7'h73, 7'h0F}) begin
            fmt = 3'd1; imm = w[31:20];
        end else if (op == 7'h23) begin
            fmt = 3'd2; imm = {w[31:25], w[11:7]};
        end else if (op == 7'h63) begin
            // Branch offset bits 12:1 of the B-immediate
            logic [12:0] off;
            off = {w[31], w[7], w[30:25], w[11:8], 1'b0};
            fmt = 3'd3; imm = off[12:1];
        end else if (op inside {7'h37, 7'h17}) fmt = 3'd4;
        else if (op == 7'h6F) fmt = 3'd5;
        else if (op != 7'h33) ill = 1'b1;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_inst = 32'h13; m_pc = 0; m_imm = 0; m_fmt = 0; m_ill = 0; m_cnt = 0;
    endtask

    task automatic model_step();
        bit rdy;
        rdy = !ifc.flush && (!m_valid || ifc.out_ready);
        if (m_valid && !ifc.out_ready && m_cnt < CNT_MAX) m_cnt++;
        if (ifc.flush) m_valid = 0;
        else if (ifc.in_valid && rdy) begin
            m_valid = 1;
            m_inst  = ifc.in_inst;
            m_pc    = ifc.in_pc;
            ref_decode(ifc.in_inst, m_imm, m_fmt, m_ill);
        end else if (m_valid && ifc.out_ready) m_valid = 0;
    endtask

    task automatic check_outputs();
        check_eq("out_valid",   {31'b0, ifc.out_valid},   {31'b0, m_valid});
        check_eq("out_inst",    ifc.out_inst,             m_inst);
        check_eq("out_pc",      ifc.out_pc,               m_pc);
        check_eq("out_imm12",   {20'b0, ifc.out_imm12},   {20'b0, m_imm});
        check_eq("out_imm_fmt", {29'b0, ifc.out_imm_fmt}, {29'b0, m_fmt});
        check_eq("out_illegal", {31'b0, ifc.out_illegal}, {31'b0, m_ill});
        check_eq("stall_cnt",   {28'b0, ifc.stall_cnt},   m_cnt);
    endtask

    // Inputs are expected to have been set just after the previous edge.
    task automatic run_cycle();
        bit rdy_exp;
        #1;
        rdy_exp = !ifc.flush && (!m_valid || ifc.out_ready);
        check_eq("in_ready", {31'b0, ifc.in_ready}, {31'b0, rdy_exp});
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic drive(input bit v, input logic [31:0] inst, input logic [31:0] pc,
                         input bit ordy, input bit fl);
        ifc.in_valid  = v;
        ifc.in_inst   = inst;
        ifc.in_pc     = pc;
        ifc.out_ready = ordy;
        ifc.flush     = fl;
    endtask

    task automatic apply_reset();
        drive(0, 32'h0, 32'h0, 0, 0);
        rst = 1'b1;
        #2;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    logic [6:0] ops [0:11] = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h0F, 7'h23,
                               7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F};

    initial begin
        logic [31:0] r;
        logic [31:0] held;
        logic [6:0]  op;
        rst = 1'b0;
        drive(0, 32'h0, 32'h0, 0, 0);
        #3;
        apply_reset();

        // Single load then drain
        drive(1, 32'hFFF0_0093, 32'h100, 1, 0);
        run_cycle();
        check_eq("addi_valid", {31'b0, ifc.out_valid}, 32'd1);
        check_eq("addi_imm",   {20'b0, ifc.out_imm12}, 32'hFFF);
        check_eq("addi_fmt",   {29'b0, ifc.out_imm_fmt}, 32'd1);
        check_eq("addi_pc",    ifc.out_pc, 32'h100);
        drive(0, 32'h0, 32'h0, 1, 0);
        run_cycle();
        check_eq("addi_drain", {31'b0, ifc.out_valid}, 32'd0);

        // S, B, U extraction back-to-back
        drive(1, 32'hFE20_AE23, 32'h104, 1, 0);
        run_cycle();
        check_eq("sw_imm", {20'b0, ifc.out_imm12}, 32'hFFC);
        check_eq("sw_fmt", {29'b0, ifc.out_imm_fmt}, 32'd2);
        drive(1, 32'hFE00_0CE3, 32'h108, 1, 0);
        run_cycle();
        check_eq("beq_imm", {20'b0, ifc.out_imm12}, 32'hFFC);
        check_eq("beq_fmt", {29'b0, ifc.out_imm_fmt}, 32'd3);
        drive(1, 32'h1234_5037, 32'h10C, 1, 0);
        run_cycle();
        check_eq("lui_imm", {20'b0, ifc.out_imm12}, 32'h0);
        check_eq("lui_fmt", {29'b0, ifc.out_imm_fmt}, 32'd4);

        // Back-pressure
        apply_reset();
        drive(1, 32'h0050_0113, 32'h200, 1, 0);
        run_cycle();
        drive(1, 32'h0020_0093, 32'h204, 0, 0);
        for (int i = 0; i < 5; i++) run_cycle();
        check_eq("bp_ready", {31'b0, ifc.in_ready}, 32'd0);
        check_eq("bp_inst",  ifc.out_inst, 32'h0050_0113);
        check_eq("bp_stall", {28'b0, ifc.stall_cnt}, 32'd5);
        drive(1, 32'h0020_0093, 32'h204, 1, 0);
        run_cycle();
        check_eq("bp_accept", ifc.out_inst, 32'h0020_0093);
        check_eq("bp_hold",   {28'b0, ifc.stall_cnt}, 32'd5);

        // Flush discards held and blocks the concurrent offer
        drive(1, 32'h0010_0093, 32'h300, 0, 1);
        #1;
        check_eq("fl_ready", {31'b0, ifc.in_ready}, 32'd0);
        run_cycle();
        check_eq("fl_valid", {31'b0, ifc.out_valid}, 32'd0);
        check_eq("fl_inst",  ifc.out_inst, 32'h0020_0093);
        drive(0, 32'h0, 32'h0, 0, 1);
        run_cycle();

        // Illegal opcodes
        drive(1, 32'h0000_007F, 32'h400, 1, 0);
        run_cycle();
        check_eq("ill_7f", {31'b0, ifc.out_illegal}, 32'd1);
        check_eq("ill_7f_fmt", {29'b0, ifc.out_imm_fmt}, 32'd0);
        drive(1, 32'h0000_0000, 32'h404, 1, 0);
        run_cycle();
        check_eq("ill_00", {31'b0, ifc.out_illegal}, 32'd1);

        // Saturation
        drive(1, 32'h0000_0033, 32'h408, 0, 0);
        for (int i = 0; i < CNT_MAX + 4; i++) run_cycle();
        check_eq("sat_cnt", {28'b0, ifc.stall_cnt}, CNT_MAX);

        // Async reset mid-stall
        apply_reset();
        drive(1, 32'h0010_0093, 32'h500, 1, 0);
        run_cycle();
        drive(0, 32'h0, 32'h0, 0, 0);
        for (int i = 0; i < 3; i++) run_cycle();
        check_eq("ar_pre", {28'b0, ifc.stall_cnt}, 32'd3);
        #2;
        rst = 1'b1;
        #1;
        check_eq("ar_valid", {31'b0, ifc.out_valid}, 32'd0);
        check_eq("ar_cnt",   {28'b0, ifc.stall_cnt}, 32'd0);
        check_eq("ar_inst",  ifc.out_inst, 32'h0000_0013);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            r  = $urandom();
            op = ops[$urandom_range(0, 11)];
            if ($urandom_range(0, 9) == 0) op = r[6:0];
            held = {r[31:7], op};
            drive($urandom_range(0, 9) < 7, held, $urandom(),
                  $urandom_range(0, 9) < 6, $urandom_range(0, 9) == 0);
            run_cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
